// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 types: branch kinds, fetch-unit states, NOP encoding.
package rv32_pkg;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } branch_type_e;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_FETCH,
        PC_KILL,
        PC_HOLD
    } pc_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch sequencer: PC, imem handshake, skid and redirect kill.
module program_counter
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        b_out,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        flush
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] pending_q, pending_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect  = jump | b_out;
    assign target    = word_align(jump ? jump_target : branch_target);
    assign pc_plus4  = pc_q + 32'd4;

    // The request is held in KILL so the in-flight access completes before the new PC is issued.
    assign imem_req  = (state_q == PC_FETCH) || (state_q == PC_KILL);
    assign imem_addr = pc_q;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign flush       = flush_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        flush_d       = 1'b0;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        pending_d     = pending_q;

        if (redirect) begin
            instr_valid_d = 1'b0;
            flush_d       = 1'b1;
        end

        case (state_q)
            PC_BOOT: begin
                state_d = PC_FETCH;
                if (redirect) begin
                    pc_d = target;
                end
            end
            PC_FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        pending_d = target;
                        state_d   = PC_KILL;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = PC_HOLD;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                end
            end
            PC_KILL: begin
                if (redirect) begin
                    pending_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = PC_FETCH;
                end
            end
            PC_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = PC_FETCH;
                end else if (!stall) begin
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = PC_FETCH;
                end
            end
            default: state_d = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= PC_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
            pending_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            pending_q     <= pending_d;
        end
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned).
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
 clk  in  1  clock, rising edge
 nrst  in  1  asynchronous active-low reset
 b_out  in  1  conditional branch taken (from branch_logic)
 branch_target  in  32  PC-relative branch target
 jump  in  1  JAL/JALR taken
 jump_target  in  32  jump target
 stall  in  1  decode not accepting; hold instruction outputs
 imem_req  out  1  fetch request
 imem_addr  out  32  fetch address
 imem_ack  in  1  fetch complete, imem_rdata valid
 imem_rdata  in  32  fetched instruction word
 instr  out  32  instruction to decode
 instr_pc  out  32  address of instr
 instr_valid  out  1  instr is a valid, not-killed instruction
 flush  out  1  one-cycle pulse: wrong-path instruction killed

Function
REQ-003 SHALL implement states BOOT, FETCH, KILL, HOLD; all outputs registered except imem_req/imem_addr, which decode from state and pc.
REQ-004 SHALL define redirect = jump | b_out; target = jump ? jump_target : branch_target (jump wins); bits [1:0] of target forced to 0.
REQ-005 SHALL drive imem_req=1 in FETCH and KILL, 0 in BOOT and HOLD; imem_addr = pc in every state.
REQ-006 SHALL hold imem_req and imem_addr stable from request until the ack cycle; stall SHALL NOT drop an outstanding request.
REQ-007 BOOT: one cycle, req low, then FETCH.
REQ-008 FETCH, ack, no redirect, stall=0: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; stay FETCH (back-to-back fetch, ack-to-valid latency 1 cycle).
REQ-009 FETCH, ack, no redirect, stall=1: rdata/pc to skid register, pc<=pc+4, go HOLD; instr outputs unchanged.
REQ-010 HOLD, stall falls, no redirect: skid to instr/instr_pc, instr_valid<=1, go FETCH.
REQ-011 FETCH, no ack, stall=0, instr_valid=1: instr_valid<=0 (consumed, nothing new).
REQ-012 FETCH, redirect, ack same cycle: rdata discarded, pc<=target, stay FETCH.
REQ-013 FETCH, redirect, no ack: target to pending register, go KILL.
REQ-014 KILL: on ack discard rdata, pc<=pending, go FETCH; new redirect in KILL overwrites pending (newest wins).
REQ-015 HOLD, redirect: skid discarded, pc<=target, go FETCH.
REQ-016 Any redirect SHALL clear instr_valid and assert flush next cycle, for exactly one cycle per redirect, regardless of stall.
REQ-017 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 With stall=1 and no redirect, instr, instr_pc, instr_valid SHALL stay stable.

Reset
REQ-019 nrst low SHALL asynchronously force: state BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, flush=0, skid/pending=0.
REQ-020 Reset mid-request SHALL abandon the request; a late ack in BOOT SHALL be ignored.

Structure
REQ-021 State enum and NOP constant (32'h0000_0013) SHALL live in the shared rv32 package beside the branch-type enum.
REQ-022 Flat module, no sub-module; target about 150-250 RTL lines.

Verification
REQ-023 Reset, RESET_PC=0, ack every req cycle -> imem_addr 0,4,8; instr_pc 0,4,8 on consecutive cycles after one BOOT cycle.
REQ-024 b_out=1, branch_target=32'h0000_0100 on an ack cycle -> next imem_addr 0x100, flush pulse 1 cycle, instr_valid 0 that cycle.
REQ-025 jump=1, jump_target=32'h0000_0203, b_out=1, branch_target=0x40 together -> fetch 0x200.
REQ-026 Redirect to 0x80 with memory acking 3 cycles late -> old ack data discarded, next req at 0x80, no valid wrong-path instr.
REQ-027 stall=1 during ack of addr 0x10 -> HOLD, req low, outputs frozen; stall drop -> instr_pc=0x10, instr_valid=1, fetch resumes at 0x14.
REQ-028 pc=32'hFFFF_FFFC, ack -> next imem_addr 32'h0000_0000; nrst pulsed mid-request -> all outputs at reset values immediately.
